// File: rtl/vga_scanout.sv
// VGA 640x480@60 scan-out: timing counters, frame-buffer addressing, aligned output pipeline.
// Optional 32-pixel checkerboard test pattern compiled in with VGA_TEST_PATTERN_EN.
module vga_scanout #(
   parameter int RD_LAT = 1,
   parameter int H_ACT  = 640,
   parameter int V_ACT  = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        outdata_r,
   input  logic        outdata_g,
   input  logic        outdata_b,
   input  logic        pattern_sel,
   output logic [18:0] vga_addr_2,
   output logic        hsync,
   output logic        vsync,
   output logic        vga_r,
   output logic        vga_g,
   output logic        vga_b,
   output logic        blank_n
);

   localparam logic [9:0] H_VIS  = 10'(H_ACT);
   localparam logic [9:0] H_LAST = 10'(H_ACT + 159);
   localparam logic [9:0] HS_BEG = 10'(H_ACT + 16);
   localparam logic [9:0] HS_END = 10'(H_ACT + 111);
   localparam logic [9:0] V_VIS  = 10'(V_ACT);
   localparam logic [9:0] V_LAST = 10'(V_ACT + 44);
   localparam logic [9:0] VS_BEG = 10'(V_ACT + 10);
   localparam logic [9:0] VS_END = 10'(V_ACT + 11);

   logic [9:0]        h_cnt_q, h_cnt_d;
   logic [9:0]        v_cnt_q, v_cnt_d;
   logic [18:0]       addr_q, addr_d;
   logic [18:0]       addr2_q, addr2_d;
   logic [RD_LAT+1:0] vis_q, vis_d;
   logic [RD_LAT+1:0] hs_q, hs_d;
   logic [RD_LAT+1:0] vs_q, vs_d;
   logic [2:0]        rgb_q, rgb_d;
   logic              vis0, hs0, vs0;
   logic              wrap_h, wrap_v;
   logic [2:0]        rgb_in;

`ifdef VGA_TEST_PATTERN_EN
   logic [RD_LAT:0][2:0] pat_q, pat_d;
   logic [2:0]           pat0;
`else
   logic unused_pattern_sel;
   assign unused_pattern_sel = pattern_sel;
`endif

   always_comb begin
      wrap_h  = (h_cnt_q == H_LAST);
      wrap_v  = wrap_h && (v_cnt_q == V_LAST);
      h_cnt_d = wrap_h ? 10'd0 : h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (wrap_v) begin
         v_cnt_d = 10'd0;
      end else if (wrap_h) begin
         v_cnt_d = v_cnt_q + 10'd1;
      end
      vis0 = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      hs0  = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
      vs0  = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
      // address counter tracks the next visible pixel; only wraps at frame end
      addr_d = addr_q;
      if (wrap_v) begin
         addr_d = 19'd0;
      end else if (vis0) begin
         addr_d = addr_q + 19'd1;
      end
      addr2_d = vis0 ? addr_q : addr2_q;
      vis_d   = {vis_q[RD_LAT:0], vis0};
      hs_d    = {hs_q[RD_LAT:0], hs0};
      vs_d    = {vs_q[RD_LAT:0], vs0};
      rgb_in  = {outdata_r, outdata_g, outdata_b};
`ifdef VGA_TEST_PATTERN_EN
      pat0  = {h_cnt_q[5], v_cnt_q[5], h_cnt_q[5] ^ v_cnt_q[5]};
      pat_d = {pat_q[RD_LAT-1:0], pat0};
      if (pattern_sel) begin
         rgb_in = pat_q[RD_LAT];
      end
`endif
      // colour register samples the stage that lines up with returning data
      rgb_d = vis_q[RD_LAT] ? rgb_in : 3'b000;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         addr_q  <= '0;
         addr2_q <= '0;
         vis_q   <= '0;
         hs_q    <= '1;
         vs_q    <= '1;
         rgb_q   <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         addr_q  <= addr_d;
         addr2_q <= addr2_d;
         vis_q   <= vis_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         rgb_q   <= rgb_d;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_q <= '0;
      end else begin
         pat_q <= pat_d;
      end
   end
`endif

   assign vga_addr_2 = addr2_q;
   assign hsync      = hs_q[RD_LAT+1];
   assign vsync      = vs_q[RD_LAT+1];
   assign blank_n    = vis_q[RD_LAT+1];
   assign vga_r      = rgb_q[2];
   assign vga_g      = rgb_q[1];
   assign vga_b      = rgb_q[0];

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a reduced 64x40 raster (224x85 total) with RD_LAT=2.
// Frame-buffer model returns {r,g,b} = addr[0], addr[1], addr[2], or all-ones when fill is set.
module tb_vga_scanout;

   localparam int RD_LAT = 2;
   localparam int H_ACT  = 64;
   localparam int V_ACT  = 40;
   localparam int H_TOT  = 224;
   localparam int FRAME  = 19040;
   localparam int LAT    = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        outdata_r, outdata_g, outdata_b;
   logic        pattern_sel = 1'b0;
   logic        fill = 1'b0;
   logic [18:0] vga_addr_2;
   logic        hsync, vsync, vga_r, vga_g, vga_b, blank_n;
   logic [18:0] a1 = '0;
   logic [18:0] a2 = '0;

   int checks = 0;
   int failures = 0;
   int ecnt = 0;

   vga_scanout #(.RD_LAT(RD_LAT), .H_ACT(H_ACT), .V_ACT(V_ACT)) dut (
      .clk(clk), .reset(reset),
      .outdata_r(outdata_r), .outdata_g(outdata_g), .outdata_b(outdata_b),
      .pattern_sel(pattern_sel), .vga_addr_2(vga_addr_2),
      .hsync(hsync), .vsync(vsync),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .blank_n(blank_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      a1 <= vga_addr_2;
      a2 <= a1;
   end

   assign outdata_r = fill | a2[0];
   assign outdata_g = fill | a2[1];
   assign outdata_b = fill | a2[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   initial begin
      int hs_run, hs_pulses, hs_bad, vs_low, vs_pulses, vis_cnt;
      int blank_bad, addr_bad, fill_bad;
      logic hs_prev, vs_prev;

      // reset values
      repeat (3) step();
      chk("rst_addr", vga_addr_2, 0);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_blank", blank_n, 0);
      chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);

      // one full output frame after release
      reset = 1'b1;
      ecnt = 0;
      hs_run = 0; hs_pulses = 0; hs_bad = 0;
      vs_low = 0; vs_pulses = 0; vis_cnt = 0;
      blank_bad = 0; addr_bad = 0;
      hs_prev = 1'b1; vs_prev = 1'b1;
      for (int n = 1; n <= FRAME + 3; n++) begin
         step();
         if (n <= H_ACT && vga_addr_2 != 19'(n - 1)) addr_bad++;
         if (n == 1) chk("addr_first", vga_addr_2, 0);
         if (n == 64) chk("addr_line0_end", vga_addr_2, 63);
         if (n == 225) chk("addr_line1", vga_addr_2, 64);
         if (n == 8800) chk("addr_last", vga_addr_2, 2559);
         if (n == FRAME) chk("addr_hold", vga_addr_2, 2559);
         if (n == FRAME + 1) chk("addr_wrap", vga_addr_2, 0);
         if (n == 3) chk("blank_pre", blank_n, 0);
         if (n == 4) chk("blank_rise", blank_n, 1);
         if (n == 4) chk("lat_r0", vga_r, 0);
         if (n == 5) chk("lat_r1", vga_r, 1);
         if (n == 6) chk("lat_r2", vga_r, 0);
         if (n == 68) chk("blank_fall", blank_n, 0);
         if (!hsync) hs_run++;
         if (!hsync && hs_prev) hs_pulses++;
         if (hsync && !hs_prev) begin
            if (hs_run != 96) hs_bad++;
            hs_run = 0;
         end
         if (!vsync) vs_low++;
         if (!vsync && vs_prev) vs_pulses++;
         if (blank_n) vis_cnt++;
         if (!blank_n && {vga_r, vga_g, vga_b} != 3'b000) blank_bad++;
         hs_prev = hsync;
         vs_prev = vsync;
      end
      chk("addr_line0_seq", addr_bad, 0);
      chk("hs_pulses", hs_pulses, 85);
      chk("hs_width", hs_bad, 0);
      chk("vs_pulses", vs_pulses, 1);
      chk("vs_low", vs_low, 448);
      chk("vis_count", vis_cnt, 2560);
      chk("blank_rgb", blank_bad, 0);

      // all-ones buffer: colour only while blank_n is high
      fill = 1'b1;
      repeat (3) step();
      blank_bad = 0; fill_bad = 0; vis_cnt = 0;
      for (int n = 0; n < FRAME; n++) begin
         step();
         if (blank_n) vis_cnt++;
         if (!blank_n && {vga_r, vga_g, vga_b} != 3'b000) blank_bad++;
         if (blank_n && {vga_r, vga_g, vga_b} != 3'b111) fill_bad++;
      end
      chk("fill_blank", blank_bad, 0);
      chk("fill_vis", fill_bad, 0);
      chk("fill_count", vis_cnt, 2560);
      fill = 1'b0;

      // mid-frame reset at line 20
      for (int n = 0; n < 2 * FRAME && (ecnt % FRAME) != 20 * H_TOT; n++) step();
      chk("mid_pos", ecnt % FRAME, 20 * H_TOT);
      reset = 1'b0;
      #1;
      chk("mid_rst_addr", vga_addr_2, 0);
      chk("mid_rst_sync", {hsync, vsync}, 2'b11);
      chk("mid_rst_blank", blank_n, 0);
      chk("mid_rst_rgb", {vga_r, vga_g, vga_b}, 0);
      repeat (3) step();
      chk("mid_hold_addr", vga_addr_2, 0);
      chk("mid_hold_blank", blank_n, 0);
      reset = 1'b1;
      ecnt = 0;
      step();
      chk("restart_addr0", vga_addr_2, 0);
      step();
      chk("restart_addr1", vga_addr_2, 1);
      while (ecnt < 15000 && vsync) step();
      chk("vsync_after_rst", ecnt, 50 * H_TOT + LAT);

      // pattern select
      reset = 1'b0;
      step();
      pattern_sel = 1'b1;
      reset = 1'b1;
      ecnt = 0;
      while (ecnt < 36) step();
`ifdef VGA_TEST_PATTERN_EN
      chk("pat_32_0", {vga_r, vga_g, vga_b}, 3'b101);
      while (ecnt < 7200 + LAT) step();
      chk("pat_32_32", {vga_r, vga_g, vga_b}, 3'b110);
`else
      chk("nopat_32_0", {vga_r, vga_g, vga_b}, 3'b000);
      step();
      chk("nopat_33_0", {vga_r, vga_g, vga_b}, 3'b100);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
